// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for a single-port synchronous data SRAM, with an optional ownership lock.
// Define ARB_STATS_EN to add saturating grant/conflict counters and a STAT_CLR input.
module dmem_arbiter #(
  parameter int AW       = 10,
  parameter int BW       = 32,
  parameter int LOCK_MAX = 15
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic          WE0,
  input  logic          WE1,
  input  logic          LOCK0,
  input  logic          LOCK1,
  input  logic [AW-1:0] ADDR0,
  input  logic [AW-1:0] ADDR1,
  input  logic [BW-1:0] WDATA0,
  input  logic [BW-1:0] WDATA1,
  output logic          GNT0,
  output logic          GNT1,
  output logic          RVALID0,
  output logic          RVALID1,
  output logic [BW-1:0] RDATA,
  output logic          SRAM_CSN,
  output logic          SRAM_WEN,
  output logic [AW-1:0] SRAM_A,
  output logic [BW-1:0] SRAM_DI,
`ifdef ARB_STATS_EN
  input  logic          STAT_CLR,
  output logic [15:0]   STAT_GNT0,
  output logic [15:0]   STAT_GNT1,
  output logic [15:0]   STAT_CONFLICT,
`endif
  input  logic [BW-1:0] SRAM_DOUT
);

  typedef struct packed {
    logic          req;
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

  req_t [1:0] rq;
  state_t     state;
  logic       prio;
  logic [7:0] lock_cnt;
  logic [7:0] cnt_inc;
  logic [1:0] rv_pipe;
  logic [1:0] gnt;
  logic       any;
  logic       sel;
  logic       own;

  assign rq[0] = '{req: REQ0, we: WE0, lock: LOCK0, addr: ADDR0, wdata: WDATA0};
  assign rq[1] = '{req: REQ1, we: WE1, lock: LOCK1, addr: ADDR1, wdata: WDATA1};

  // Grant is combinational so the SRAM access happens at the very edge that samples it.
  always_comb begin
    gnt = 2'b00;
    if (!RST) begin
      case (state)
        IDLE: begin
          if (rq[0].req && rq[1].req) gnt[prio] = 1'b1;
          else                        gnt = {rq[1].req, rq[0].req};
        end
        OWN0:    gnt[0] = rq[0].req;
        OWN1:    gnt[1] = rq[1].req;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign any = |gnt;
  assign sel = gnt[1];  // no grant selects port 0, so the idle SRAM bus shows port 0
  assign own = (state == OWN1);
  assign cnt_inc = lock_cnt + 8'd1;

  assign GNT0     = gnt[0];
  assign GNT1     = gnt[1];
  assign SRAM_CSN = ~any;
  assign SRAM_WEN = ~(any & rq[sel].we);
  assign SRAM_A   = rq[sel].addr;
  assign SRAM_DI  = rq[sel].wdata;
  assign RVALID0  = rv_pipe[0];
  assign RVALID1  = rv_pipe[1];
  assign RDATA    = SRAM_DOUT;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      prio     <= 1'b0;
      lock_cnt <= 8'd0;
      rv_pipe  <= 2'b00;
    end else begin
      rv_pipe <= gnt & ~{rq[1].we, rq[0].we};
      if (any) prio <= ~sel;
      case (state)
        IDLE: begin
          if (gnt[0] && rq[0].lock) begin
            state    <= OWN0;
            lock_cnt <= 8'd0;
          end else if (gnt[1] && rq[1].lock) begin
            state    <= OWN1;
            lock_cnt <= 8'd0;
          end
        end
        OWN0, OWN1: begin
          // Every owned cycle counts, granted or stalled, so a lost owner cannot starve the other port.
          lock_cnt <= cnt_inc;
          if ((gnt[own] && !rq[own].lock) || cnt_inc == LOCK_LIM) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] st_g0, st_g1, st_cf;

  always_ff @(posedge CLK) begin
    if (RST || STAT_CLR) begin
      st_g0 <= 16'd0;
      st_g1 <= 16'd0;
      st_cf <= 16'd0;
    end else begin
      if (gnt[0] && st_g0 != 16'hFFFF)    st_g0 <= st_g0 + 16'd1;
      if (gnt[1] && st_g1 != 16'hFFFF)    st_g1 <= st_g1 + 16'd1;
      if (REQ0 && REQ1 && st_cf != 16'hFFFF) st_cf <= st_cf + 16'd1;
    end
  end

  assign STAT_GNT0     = st_g0;
  assign STAT_GNT1     = st_g1;
  assign STAT_CONFLICT = st_cf;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: SRAM model on the pins plus a transaction-level reference model.
// Stats checks are compiled in when ARB_STATS_EN is defined.
module tb_dmem_arbiter;
  localparam int AW = 10;
  localparam int BW = 32;
  localparam int LOCK_MAX = 15;

  logic          CLK = 1'b0;
  logic          RST;
  logic          REQ0, REQ1, WE0, WE1, LOCK0, LOCK1;
  logic [AW-1:0] ADDR0, ADDR1;
  logic [BW-1:0] WDATA0, WDATA1;
  logic          GNT0, GNT1, RVALID0, RVALID1;
  logic [BW-1:0] RDATA;
  logic          SRAM_CSN, SRAM_WEN;
  logic [AW-1:0] SRAM_A;
  logic [BW-1:0] SRAM_DI;
  logic [BW-1:0] SRAM_DOUT;
`ifdef ARB_STATS_EN
  logic          STAT_CLR;
  logic [15:0]   STAT_GNT0, STAT_GNT1, STAT_CONFLICT;
  int            m_sg0, m_sg1, m_scf;
`endif

  always #5 CLK = ~CLK;

  dmem_arbiter #(.AW(AW), .BW(BW), .LOCK_MAX(LOCK_MAX)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1), .LOCK0(LOCK0), .LOCK1(LOCK1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1), .RDATA(RDATA),
    .SRAM_CSN(SRAM_CSN), .SRAM_WEN(SRAM_WEN), .SRAM_A(SRAM_A), .SRAM_DI(SRAM_DI),
`ifdef ARB_STATS_EN
    .STAT_CLR(STAT_CLR), .STAT_GNT0(STAT_GNT0), .STAT_GNT1(STAT_GNT1),
    .STAT_CONFLICT(STAT_CONFLICT),
`endif
    .SRAM_DOUT(SRAM_DOUT)
  );

  function automatic logic [BW-1:0] init_val(input int a);
    if (a == 16) return 32'hDEADBEEF;
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // SRAM behavioural model driven only by the DUT pins
  logic [BW-1:0] sram_w [int];
  always @(posedge CLK) begin
    if (!SRAM_CSN) begin
      if (!SRAM_WEN) sram_w[int'(SRAM_A)] = SRAM_DI;
      else SRAM_DOUT <= sram_w.exists(int'(SRAM_A)) ? sram_w[int'(SRAM_A)] : init_val(int'(SRAM_A));
    end
  end

  // Reference model: memory image, owner (-1 none), priority, owned-cycle count, pending read
  logic [BW-1:0] refm [0:(1<<AW)-1];
  int            m_own = -1, m_prio = 0, m_held = 0;
  bit            m_rv0 = 0, m_rv1 = 0;
  logic [BW-1:0] m_rdata;
  int            total = 0, bad = 0;
  int            last_g;
  logic          obs_g0, obs_g1, obs_csn;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the reference model at the edge.
  task automatic tick();
    int g;
    logic [AW-1:0] ea;
    logic [BW-1:0] ed;
    logic ewen;
    #3;
    g = -1;
    if (!RST) begin
      if (m_own >= 0) begin
        if ((m_own == 0) ? REQ0 : REQ1) g = m_own;
      end else if (REQ0 && REQ1) g = m_prio;
      else if (REQ0) g = 0;
      else if (REQ1) g = 1;
    end
    ea   = (g == 1) ? ADDR1 : ADDR0;
    ed   = (g == 1) ? WDATA1 : WDATA0;
    ewen = (g < 0) ? 1'b1 : ((g == 0) ? !WE0 : !WE1);
    chk("gnt0", GNT0, g == 0);
    chk("gnt1", GNT1, g == 1);
    chk("csn", SRAM_CSN, g < 0);
    chk("wen", SRAM_WEN, ewen);
    chk("addr", SRAM_A, ea);
    chk("wdata", SRAM_DI, ed);
    chk("rv0", RVALID0, m_rv0);
    chk("rv1", RVALID1, m_rv1);
    if (m_rv0 || m_rv1) chk("rdata", RDATA, m_rdata);
`ifdef ARB_STATS_EN
    chk("st_g0", STAT_GNT0, 64'(m_sg0));
    chk("st_g1", STAT_GNT1, 64'(m_sg1));
    chk("st_cf", STAT_CONFLICT, 64'(m_scf));
`endif
    obs_g0 = GNT0; obs_g1 = GNT1; obs_csn = SRAM_CSN; last_g = g;
    @(posedge CLK);
    if (RST) begin
      m_own = -1; m_prio = 0; m_held = 0; m_rv0 = 0; m_rv1 = 0;
`ifdef ARB_STATS_EN
      m_sg0 = 0; m_sg1 = 0; m_scf = 0;
`endif
    end else begin
      m_rv0 = (g == 0) && !WE0;
      m_rv1 = (g == 1) && !WE1;
      if (g >= 0) begin
        if ((g == 0) ? WE0 : WE1) refm[ea] = ed;
        else m_rdata = refm[ea];
        m_prio = 1 - g;
      end
      if (m_own < 0) begin
        if (g >= 0 && ((g == 0) ? LOCK0 : LOCK1)) begin m_own = g; m_held = 0; end
      end else begin
        m_held++;
        if ((g == m_own && !((m_own == 0) ? LOCK0 : LOCK1)) || m_held == LOCK_MAX) m_own = -1;
      end
`ifdef ARB_STATS_EN
      if (STAT_CLR) begin m_sg0 = 0; m_sg1 = 0; m_scf = 0; end
      else begin
        if (g == 0 && m_sg0 < 65535) m_sg0++;
        if (g == 1 && m_sg1 < 65535) m_sg1++;
        if (REQ0 && REQ1 && m_scf < 65535) m_scf++;
      end
`endif
    end
    #1;
  endtask

  task automatic idle_in();
    REQ0 = 0; REQ1 = 0; WE0 = 0; WE1 = 0; LOCK0 = 0; LOCK1 = 0;
  endtask

  task automatic do_reset();
    idle_in();
    RST = 1; tick(); RST = 0;
  endtask

  function automatic logic [AW-1:0] raddr();
    if ($urandom_range(0, 7) == 0) return 10'h3FF;
    return 10'($urandom_range(0, 15));
  endfunction

  initial begin
    int seq, f0, f1;
    for (int i = 0; i < (1 << AW); i++) refm[i] = init_val(i);
    idle_in();
    ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
`ifdef ARB_STATS_EN
    STAT_CLR = 0;
`endif
    RST = 1;
    @(posedge CLK); #1;
    do_reset();
    chk("rst_rv0", RVALID0, 0);
    chk("rst_wen", SRAM_WEN, 1);

    // single read from port 0
    REQ0 = 1; WE0 = 0; ADDR0 = 10'h010;
    tick();
    chk("t1_gnt0", obs_g0, 1);
    chk("t1_csn", obs_csn, 0);
    REQ0 = 0;
    chk("t1_rv0", RVALID0, 1);
    chk("t1_rdata", RDATA, 32'hDEADBEEF);
    chk("t1_rv1", RVALID1, 0);
    tick();

    // both ports reading continuously alternate
    do_reset();
    REQ0 = 1; ADDR0 = 10'h001; REQ1 = 1; ADDR1 = 10'h002;
    seq = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      seq = (seq << 1) | int'(obs_g1);
      chk("t2_rv0", RVALID0, k % 2 == 0);
      chk("t2_rv1", RVALID1, k % 2 == 1);
      chk("t2_data", RDATA, (k % 2 == 0) ? refm[1] : refm[2]);
    end
    chk("t2_seq", seq, 4'b0101);
    idle_in();
    tick();

    // locked write-then-read by port 1 while port 0 waits
    REQ0 = 1; WE0 = 1; ADDR0 = 10'h005; WDATA0 = $urandom;
    tick();
    WE0 = 0; ADDR0 = 10'h007;
    REQ1 = 1; WE1 = 1; LOCK1 = 1; ADDR1 = 10'h3FF; WDATA1 = 32'h12345678;
    tick();
    chk("t3_g0_a", obs_g0, 0);
    WE1 = 0; LOCK1 = 0;
    tick();
    chk("t3_g0_b", obs_g0, 0);
    chk("t3_g1_b", obs_g1, 1);
    REQ1 = 0;
    chk("t3_rv1", RVALID1, 1);
    chk("t3_rdata", RDATA, 32'h12345678);
    tick();
    chk("t3_g0_c", obs_g0, 1);
    idle_in();
    tick();

    // lock timeout releases port 1
    do_reset();
    f0 = -1; f1 = -1;
    REQ1 = 1; LOCK0 = 1;
    for (int i = 0; i < 22; i++) begin
      REQ0 = (i % 2 == 0);
      tick();
      if (obs_g0 && f0 < 0) f0 = i;
      if (obs_g1 && f1 < 0) begin f1 = i; REQ1 = 0; end
    end
    chk("t4_dist", 64'(f1 - f0), 16);

    // reset right after a read grant
    do_reset();
    REQ0 = 1; ADDR0 = 10'h004;
    tick();
    RST = 1; REQ1 = 1; ADDR1 = 10'h008;
    tick();
    chk("t5_csn", obs_csn, 1);
    chk("t5_gnt", obs_g0 | obs_g1, 0);
    RST = 0;
    chk("t5_rv0", RVALID0, 0);
    tick();
    chk("t5_first", obs_g0, 1);
    idle_in();
    tick();

`ifdef ARB_STATS_EN
    do_reset();
    REQ0 = 1; REQ1 = 1;
    for (int i = 0; i < 10; i++) tick();
    idle_in();
    chk("t6_conf", STAT_CONFLICT, 10);
    chk("t6_sum", 64'(STAT_GNT0) + 64'(STAT_GNT1), 10);
    STAT_CLR = 1; tick(); STAT_CLR = 0;
    chk("t6_clr", {STAT_GNT0, STAT_GNT1, STAT_CONFLICT}, 0);
`endif

    // random traffic; a requester holds its request until it is granted
    idle_in();
    for (int i = 0; i < 800; i++) begin
      RST = ($urandom_range(0, 99) == 0);
      if (!(REQ0 && last_g != 0)) begin
        REQ0 = ($urandom_range(0, 9) < 6); WE0 = ($urandom_range(0, 2) == 0);
        LOCK0 = ($urandom_range(0, 3) == 0); ADDR0 = raddr(); WDATA0 = $urandom;
      end
      if (!(REQ1 && last_g != 1)) begin
        REQ1 = ($urandom_range(0, 9) < 6); WE1 = ($urandom_range(0, 2) == 0);
        LOCK1 = ($urandom_range(0, 3) == 0); ADDR1 = raddr(); WDATA1 = $urandom;
      end
`ifdef ARB_STATS_EN
      STAT_CLR = ($urandom_range(0, 49) == 0);
`endif
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
